log_approx: RTL

LOG_APPROX -- requirements
Module: log_approx

---
 rtl/log_approx.sv | 111 +++++++++++
 1 files changed

// File: rtl/log_approx.sv
// Three-stage pipelined natural-log approximation (Mitchell log2 scaled by ln2), valid/ready on both ports.
// Optional mantissa correction in S2 is enabled by defining LOG_MITCHELL_CORR_EN.
module log_approx #(
   parameter int TOTAL_WIDTH = 8,
   parameter int FRAC_WIDTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [TOTAL_WIDTH-1:0] x,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [TOTAL_WIDTH-1:0] y,
   output logic                   domain_err
);

   localparam int W   = TOTAL_WIDTH;
   localparam int F   = FRAC_WIDTH;
   localparam int MW  = W - 2;
   localparam int PW  = $clog2(W);
   localparam int LW  = W + 4;
   localparam int PRW = LW + 9;
   localparam logic [7:0] LN2 = 8'd177;
   localparam logic signed [PRW-1:0] YMAX = PRW'(2 ** (W - 1) - 1);
   localparam logic signed [PRW-1:0] YMIN = -YMAX - 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // Every stage shifts together whenever the output register is empty or being drained.
   logic adv;

   logic                  v1_q, e1_q;
   logic [PW-1:0]         p1_q;
   logic [MW-1:0]         f1_q;
   logic                  v2_q, e2_q;
   logic signed [LW-1:0]  l2_q;
   logic                  ov_q, err_q;
   logic [W-1:0]          y_q;

   logic [PW-1:0]         p_d;
   logic [MW-1:0]         f_d;
   logic                  e_d;
   logic signed [LW-1:0]  l_d;
   logic signed [PRW-1:0] prod;
   logic signed [PRW-1:0] sh;
   logic [W-1:0]          y_d;

   assign adv        = !ov_q || out_ready;
   assign in_ready   = adv;
   assign out_valid  = ov_q;
   assign y          = y_q;
   assign domain_err = err_q;

   // S1: leading-one position and the mantissa bits below it, left-aligned.
   always_comb begin
      p_d = '0;
      for (int i = 0; i < W - 1; i++) begin
         if (x[i]) p_d = PW'(i);
      end
      e_d = x[W-1] || (x == '0);
      f_d = MW'(x << (MW - int'(p_d)));
   end

`ifdef LOG_MITCHELL_CORR_EN
   localparam int CW = 2 * MW + 2;
   logic [CW-1:0] corr_prod;
   always_comb begin
      corr_prod = CW'(f1_q) * (CW'(2 ** MW) - CW'(f1_q)) * CW'(3);
   end
`endif

   // S2: log2 code with F fractional bits; exponent part may be negative.
   always_comb begin
      l_d = ((LW'(p1_q) - LW'(F)) << F) + LW'(f1_q >> (MW - F));
`ifdef LOG_MITCHELL_CORR_EN
      l_d = l_d + LW'(corr_prod >> (2 * MW + 3 - F));
`endif
   end

   // S3: scale by ln2 (Q0.8), floor via arithmetic shift, then saturate.
   always_comb begin
      prod = l2_q * $signed({1'b0, LN2});
      sh   = prod >>> 8;
      if (e2_q)           y_d = {1'b1, {(W - 1){1'b0}}};
      else if (sh > YMAX) y_d = YMAX[W-1:0];
      else if (sh < YMIN) y_d = YMIN[W-1:0];
      else                y_d = sh[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         ov_q  <= 1'b0;
         y_q   <= '0;
         err_q <= 1'b0;
      end else if (adv) begin
         v1_q  <= in_valid;
         e1_q  <= e_d;
         p1_q  <= p_d;
         f1_q  <= f_d;
         v2_q  <= v1_q;
         e2_q  <= e1_q;
         l2_q  <= l_d;
         ov_q  <= v2_q;
         err_q <= v2_q && e2_q;
         y_q   <= v2_q ? y_d : '0;
      end
   end

endmodule
